// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared pipeline types for the in-order core.
// Holds the memory1->memory2 and memory2->writeback pass structures,
// the forwarding request, the exception record, the load width encoding,
// and the memory2 FSM state type.
package cpu_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } byte_type_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      ecode;
        logic [8:0]      esubcode;
        logic [XLEN-1:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      idx;
        logic            data_valid;
        logic [XLEN-1:0] data;
    } forward_req_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ex_out;
        logic            is_mem;
        logic            is_store;
        logic            is_signed;
        byte_type_t      byte_type;
        logic [1:0]      byte_en;
        logic            is_wr_rd;
        logic            is_wr_rd_pc_plus4;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
        logic            csr_we;
        logic [13:0]     csr_addr;
        logic [XLEN-1:0] csr_wdata;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            is_wr_rd;
        logic [XLEN-1:0] rd_data;
        logic            csr_we;
        logic [13:0]     csr_addr;
        logic [XLEN-1:0] csr_wdata;
    } memory2_writeback_pass_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } m2_state_t;

    // A load that really went to the dcache: a faulting instruction never
    // issued a read, and stores completed upstream.
    function automatic logic is_waiting_load(memory1_memory2_pass_t p, excp_pass_t e);
        return p.valid & p.is_mem & ~p.is_store & ~e.valid;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte / half-word / word from an
// aligned 32-bit dcache word and sign- or zero-extends it.
// Ports:
//   word      - whole aligned word returned by the dcache
//   byte_en   - low address bits selecting the byte / half-word
//   byte_type - BYTE, HALF_WORD or WORD
//   is_signed - sign-extend when set, zero-extend otherwise
//   result    - extended load value
module load_align
    import cpu_defs::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      byte_en,
    input  logic [1:0]      byte_type,
    input  logic            is_signed,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane first, then extend it according to the width.
    // Half-word selection only looks at byte_en[1]; the low bit is ignored.
    always_comb begin
        byte_sel = word[{byte_en, 3'b000} +: 8];
        half_sel = byte_en[1] ? word[31:16] : word[15:0];
        result   = word;
        case (byte_type_t'(byte_type))
            BYTE:      result = {{24{is_signed & byte_sel[7]}}, byte_sel};
            HALF_WORD: result = {{16{is_signed & half_sel[15]}}, half_sel};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/memory2.sv
// memory2: second memory stage. Holds the instruction issued to the dcache
// by memory1, waits for the load response, aligns/extends it and hands the
// result plus any exception to writeback under valid/ready.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   flush               - kills the held instruction
//   next_rdy_in         - writeback can accept this cycle
//   rdy_in              - this stage accepts pass_in on this edge
//   pass_in             - instruction from memory1
//   excp_pass_in        - exception from earlier stages
//   dcache_rdata        - aligned load word
//   dcache_data_valid   - single-cycle pulse qualifying dcache_rdata
//   fwd_req             - forwarding request for the held instruction
//   pass_out            - result to writeback
//   excp_pass_out       - exception to writeback
module memory2
    import cpu_defs::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    next_rdy_in,
    output logic                    rdy_in,
    input  memory1_memory2_pass_t   pass_in,
    input  excp_pass_t              excp_pass_in,
    input  logic [DATA_W-1:0]       dcache_rdata,
    input  logic                    dcache_data_valid,
    output forward_req_t            fwd_req,
    output memory2_writeback_pass_t pass_out,
    output excp_pass_t              excp_pass_out
);

    m2_state_t             state;
    memory1_memory2_pass_t held;
    excp_pass_t            held_excp;
    logic [DATA_W-1:0]     hold_buf;

    logic              held_load;
    logic              incoming_load;
    logic              accept_load;
    logic              stall;
    logic              wait_flush_no_data;
    logic              out_valid;
    logic [DATA_W-1:0] load_word;
    logic [XLEN-1:0]   aligned;
    logic [XLEN-1:0]   rd_data;

    // Handshake terms. In WAIT without data the stage is stalled; a flush
    // there without data still opens rdy_in for the edge that moves to DRAIN,
    // after which DRAIN blocks input until the orphaned read returns.
    always_comb begin
        held_load          = is_waiting_load(held, held_excp);
        incoming_load      = is_waiting_load(pass_in, excp_pass_in);
        stall              = ~next_rdy_in | ((state == WAIT) & ~dcache_data_valid);
        wait_flush_no_data = (state == WAIT) & flush & ~dcache_data_valid;
        rdy_in             = (state != DRAIN)
                           & (flush | ~held.valid | (~stall & ~wait_flush_no_data));
        accept_load        = rdy_in & incoming_load & ~flush;
        out_valid          = held.valid & ~flush & ~stall & (state != DRAIN);
    end

    // In HOLD the dcache bus no longer carries our data, so align from the
    // buffered copy instead.
    assign load_word = (state == HOLD) ? hold_buf : dcache_rdata;

    load_align u_load_align (
        .word      (load_word),
        .byte_en   (held.byte_en),
        .byte_type (held.byte_type),
        .is_signed (held.is_signed),
        .result    (aligned)
    );

    // Result selection: load data wins, then link address, then ALU result.
    always_comb begin
        if (held_load) begin
            rd_data = aligned;
        end else if (held.is_wr_rd_pc_plus4) begin
            rd_data = held.pc_plus4;
        end else begin
            rd_data = held.ex_out;
        end
    end

    // Outputs to writeback and the forwarding network. Forwarding advertises
    // the destination as soon as the instruction is held, but only marks the
    // data usable once a load has its word.
    always_comb begin
        pass_out           = '0;
        pass_out.valid     = out_valid;
        pass_out.pc        = held.pc;
        pass_out.rd        = held.rd;
        pass_out.is_wr_rd  = held.is_wr_rd;
        pass_out.rd_data   = rd_data;
        pass_out.csr_we    = held.csr_we;
        pass_out.csr_addr  = held.csr_addr;
        pass_out.csr_wdata = held.csr_wdata;

        fwd_req            = '0;
        fwd_req.valid      = held.valid & held.is_wr_rd & (held.rd != 5'd0)
                           & ~flush & (state != DRAIN);
        fwd_req.idx        = held.rd;
        fwd_req.data       = rd_data;
        fwd_req.data_valid = ~held_load | (state == HOLD)
                           | ((state == WAIT) & dcache_data_valid);

        excp_pass_out       = held_excp;
        excp_pass_out.valid = held_excp.valid & out_valid;
    end

    // Input register and load FSM. A flush also squashes whatever memory1
    // presents on the same edge. A flush while a read is outstanding goes
    // through DRAIN so the late response is swallowed rather than being
    // mistaken for the next load's data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            held      <= '0;
            held_excp <= '0;
            hold_buf  <= '0;
        end else begin
            if (rdy_in) begin
                held            <= pass_in;
                held.valid      <= pass_in.valid & ~flush;
                held_excp       <= excp_pass_in;
                held_excp.valid <= excp_pass_in.valid & ~flush;
            end

            case (state)
                IDLE: begin
                    if (accept_load) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= dcache_data_valid ? IDLE : DRAIN;
                    end else if (dcache_data_valid) begin
                        if (next_rdy_in) begin
                            state <= accept_load ? WAIT : IDLE;
                        end else begin
                            state    <= HOLD;
                            hold_buf <= dcache_rdata;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (next_rdy_in) begin
                        state <= accept_load ? WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    if (dcache_data_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory2.sv
// tb_memory2: self-checking bench for memory2. A pipelined table of
// single-cycle instructions plus hand-written multi-cycle sequences; every
// accepted instruction pushes its expected result to a scoreboard that is
// popped when writeback takes pass_out.
module tb_memory2;
    import cpu_defs::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    logic                    next_rdy_in;
    logic                    rdy_in;
    memory1_memory2_pass_t   pass_in;
    excp_pass_t              excp_pass_in;
    logic [31:0]             dcache_rdata;
    logic                    dcache_data_valid;
    forward_req_t            fwd_req;
    memory2_writeback_pass_t pass_out;
    excp_pass_t              excp_pass_out;

    always #5 clk = ~clk;

    memory2 #(.DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .next_rdy_in       (next_rdy_in),
        .rdy_in            (rdy_in),
        .pass_in           (pass_in),
        .excp_pass_in      (excp_pass_in),
        .dcache_rdata      (dcache_rdata),
        .dcache_data_valid (dcache_data_valid),
        .fwd_req           (fwd_req),
        .pass_out          (pass_out),
        .excp_pass_out     (excp_pass_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        excp;
    } exp_t;

    typedef struct {
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        byte_type_t  bt;
        logic [1:0]  be;
        logic        wr_rd;
        logic        pc4;
        logic [4:0]  rd;
        logic        excp;
        logic [31:0] ex_out;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        logic        exp_fwd_v;
        logic        exp_fwd_dv;
    } vec_t;

    localparam int NV = 13;

    exp_t sb_q[$];
    exp_t drv_exp;
    vec_t vecs[NV];
    int   checks    = 0;
    int   errors    = 0;
    int   reads_out = 0;

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ex_out,
                                 input logic is_mem, input logic is_store,
                                 input logic is_signed, input byte_type_t bt,
                                 input logic [1:0] be, input logic wr_rd,
                                 input logic pc4, input logic [4:0] rd,
                                 input logic excp, input logic [31:0] exp_rd);
        pass_in                   = '0;
        pass_in.valid             = 1'b1;
        pass_in.pc                = pc;
        pass_in.ex_out            = ex_out;
        pass_in.is_mem            = is_mem;
        pass_in.is_store          = is_store;
        pass_in.is_signed         = is_signed;
        pass_in.byte_type         = bt;
        pass_in.byte_en           = be;
        pass_in.is_wr_rd          = wr_rd;
        pass_in.is_wr_rd_pc_plus4 = pc4;
        pass_in.pc_plus4          = pc + 32'd4;
        pass_in.rd                = rd;
        excp_pass_in              = '0;
        excp_pass_in.valid        = excp;
        excp_pass_in.ecode        = excp ? 6'h08 : 6'h00;
        drv_exp                   = '{pc, rd, exp_rd, excp};
    endtask

    task automatic idleInput();
        pass_in      = '0;
        excp_pass_in = '0;
    endtask

    task automatic waitSample();
        @(negedge clk);
    endtask

    // Scoreboard and read bookkeeping for the cycle being sampled, then
    // advance to just after the next active edge.
    task automatic finishCycle();
        exp_t e;
        if (dcache_data_valid) begin
            checks++;
            if (reads_out == 0) begin
                errors++;
                $display("[TB] FAIL dcache_pulse: got data_valid with %0d reads outstanding, want >0", reads_out);
            end
        end
        if (pass_out.valid && next_rdy_in) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got output pc 0x%08h, want none", pass_out.pc);
            end else begin
                e = sb_q.pop_front();
                if (pass_out.pc !== e.pc || pass_out.rd_data !== e.rd_data ||
                    pass_out.rd !== e.rd || excp_pass_out.valid !== e.excp) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got pc 0x%08h rd %0d data 0x%08h excp %0b, want pc 0x%08h rd %0d data 0x%08h excp %0b",
                             pass_out.pc, pass_out.rd, pass_out.rd_data, excp_pass_out.valid,
                             e.pc, e.rd, e.rd_data, e.excp);
                end
            end
        end
        if (flush) sb_q.delete();
        if (dcache_data_valid && reads_out > 0) reads_out--;
        if (rdy_in && pass_in.valid && !flush) begin
            sb_q.push_back(drv_exp);
            if (pass_in.is_mem && !pass_in.is_store && !excp_pass_in.valid) reads_out++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Vector fields: is_mem is_store is_signed bt be wr_rd pc4 rd excp
        //                ex_out rdata exp_rd exp_fwd_v exp_fwd_dv
        vecs[0]  = '{1'b0, 1'b0, 1'b0, WORD,      2'd0, 1'b1, 1'b0, 5'd5,  1'b0, 32'h0000_1234, 32'h0,          32'h0000_1234, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, BYTE,      2'd3, 1'b1, 1'b0, 5'd6,  1'b0, 32'h0000_4003, 32'h80FF_1234, 32'hFFFF_FF80, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, BYTE,      2'd1, 1'b1, 1'b0, 5'd7,  1'b0, 32'h0000_4001, 32'h80FF_1234, 32'h0000_0012, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, BYTE,      2'd2, 1'b1, 1'b0, 5'd8,  1'b0, 32'h0000_4002, 32'h80FF_1234, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, HALF_WORD, 2'd2, 1'b1, 1'b0, 5'd9,  1'b0, 32'h0000_4002, 32'h80FF_1234, 32'hFFFF_80FF, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, HALF_WORD, 2'd0, 1'b1, 1'b0, 5'd10, 1'b0, 32'h0000_4000, 32'h1234_F00D, 32'h0000_F00D, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, HALF_WORD, 2'd0, 1'b1, 1'b0, 5'd11, 1'b0, 32'h0000_4000, 32'h1234_F00D, 32'hFFFF_F00D, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, WORD,      2'd0, 1'b1, 1'b0, 5'd31, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, WORD,      2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'hAAAA_5555, 32'h0,          32'hAAAA_5555, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, WORD,      2'd0, 1'b1, 1'b1, 5'd1,  1'b0, 32'h0000_0099, 32'h0,          32'h0000_1028, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, WORD,      2'd0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0000_0077, 32'h0,          32'h0000_0077, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, BYTE,      2'd3, 1'b1, 1'b0, 5'd12, 1'b1, 32'h0BAD_0000, 32'h0,          32'h0BAD_0000, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, BYTE,      2'd0, 1'b1, 1'b0, 5'd13, 1'b0, 32'h0000_4000, 32'h7F7F_7FFF, 32'h0000_00FF, 1'b1, 1'b1};

        rst_n             = 1'b0;
        flush             = 1'b0;
        next_rdy_in       = 1'b1;
        dcache_data_valid = 1'b0;
        dcache_rdata      = 32'h0;
        idleInput();
        repeat (2) @(posedge clk);
        #1;

        // Reset values.
        waitSample();
        checkOutput("reset_rdy_in", {31'b0, rdy_in}, 32'd1);
        checkOutput("reset_pass_valid", {31'b0, pass_out.valid}, 32'd0);
        checkOutput("reset_fwd_valid", {31'b0, fwd_req.valid}, 32'd0);
        checkOutput("reset_excp_valid", {31'b0, excp_pass_out.valid}, 32'd0);
        checkOutput("reset_state", {30'b0, dut.state}, {30'b0, IDLE});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pipelined table: vector i enters while vector i-1 completes.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                applyStimulus(32'h1000 + 32'(i) * 32'd4, vecs[i].ex_out, vecs[i].is_mem,
                              vecs[i].is_store, vecs[i].is_signed, vecs[i].bt, vecs[i].be,
                              vecs[i].wr_rd, vecs[i].pc4, vecs[i].rd, vecs[i].excp, vecs[i].exp_rd);
            end else begin
                idleInput();
            end
            if (i > 0 && vecs[i-1].is_mem && !vecs[i-1].is_store && !vecs[i-1].excp) begin
                dcache_data_valid = 1'b1;
                dcache_rdata      = vecs[i-1].rdata;
            end else begin
                dcache_data_valid = 1'b0;
                dcache_rdata      = 32'h5A5A_5A5A;
            end
            waitSample();
            checkOutput($sformatf("vec%0d_rdy_in", i), {31'b0, rdy_in}, 32'd1);
            if (i > 0) begin
                checkOutput($sformatf("vec%0d_pass_valid", i-1), {31'b0, pass_out.valid}, 32'd1);
                checkOutput($sformatf("vec%0d_rd_data", i-1), pass_out.rd_data, vecs[i-1].exp_rd);
                checkOutput($sformatf("vec%0d_fwd_valid", i-1), {31'b0, fwd_req.valid}, {31'b0, vecs[i-1].exp_fwd_v});
                checkOutput($sformatf("vec%0d_excp_valid", i-1), {31'b0, excp_pass_out.valid}, {31'b0, vecs[i-1].excp});
                if (vecs[i-1].exp_fwd_v) begin
                    checkOutput($sformatf("vec%0d_fwd_dv", i-1), {31'b0, fwd_req.data_valid}, {31'b0, vecs[i-1].exp_fwd_dv});
                    checkOutput($sformatf("vec%0d_fwd_data", i-1), fwd_req.data, vecs[i-1].exp_rd);
                    checkOutput($sformatf("vec%0d_fwd_idx", i-1), {27'b0, fwd_req.idx}, {27'b0, vecs[i-1].rd});
                end
            end
            finishCycle();
        end
        dcache_data_valid = 1'b0;

        // LD.HU with the response three cycles after acceptance.
        applyStimulus(32'h2000, 32'h0000_4002, 1'b1, 1'b0, 1'b0, HALF_WORD, 2'd2,
                      1'b1, 1'b0, 5'd14, 1'b0, 32'h0000_80FF);
        waitSample();
        finishCycle();
        idleInput();
        for (int k = 0; k < 2; k++) begin
            waitSample();
            checkOutput($sformatf("slow_rdy_in_%0d", k), {31'b0, rdy_in}, 32'd0);
            checkOutput($sformatf("slow_fwd_dv_%0d", k), {31'b0, fwd_req.data_valid}, 32'd0);
            checkOutput($sformatf("slow_fwd_valid_%0d", k), {31'b0, fwd_req.valid}, 32'd1);
            checkOutput($sformatf("slow_pass_valid_%0d", k), {31'b0, pass_out.valid}, 32'd0);
            finishCycle();
        end
        dcache_data_valid = 1'b1;
        dcache_rdata      = 32'h80FF_1234;
        waitSample();
        checkOutput("slow_pass_valid", {31'b0, pass_out.valid}, 32'd1);
        checkOutput("slow_rd_data", pass_out.rd_data, 32'h0000_80FF);
        checkOutput("slow_fwd_dv", {31'b0, fwd_req.data_valid}, 32'd1);
        finishCycle();
        dcache_data_valid = 1'b0;

        // LD.W returning while writeback is stalled: buffered in HOLD.
        applyStimulus(32'h2100, 32'h0000_4000, 1'b1, 1'b0, 1'b0, WORD, 2'd0,
                      1'b1, 1'b0, 5'd15, 1'b0, 32'hDEAD_BEEF);
        waitSample();
        finishCycle();
        idleInput();
        next_rdy_in       = 1'b0;
        dcache_data_valid = 1'b1;
        dcache_rdata      = 32'hDEAD_BEEF;
        waitSample();
        checkOutput("hold_arrive_pass_valid", {31'b0, pass_out.valid}, 32'd0);
        checkOutput("hold_arrive_rd_data", pass_out.rd_data, 32'hDEAD_BEEF);
        checkOutput("hold_arrive_fwd_dv", {31'b0, fwd_req.data_valid}, 32'd1);
        finishCycle();
        dcache_data_valid = 1'b0;
        dcache_rdata      = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            waitSample();
            checkOutput($sformatf("hold_state_%0d", k), {30'b0, dut.state}, {30'b0, HOLD});
            checkOutput($sformatf("hold_rd_data_%0d", k), pass_out.rd_data, 32'hDEAD_BEEF);
            checkOutput($sformatf("hold_pass_valid_%0d", k), {31'b0, pass_out.valid}, 32'd0);
            checkOutput($sformatf("hold_rdy_in_%0d", k), {31'b0, rdy_in}, 32'd0);
            finishCycle();
        end
        next_rdy_in = 1'b1;
        waitSample();
        checkOutput("hold_release_valid", {31'b0, pass_out.valid}, 32'd1);
        checkOutput("hold_release_data", pass_out.rd_data, 32'hDEAD_BEEF);
        finishCycle();
        waitSample();
        checkOutput("hold_after_state", {30'b0, dut.state}, {30'b0, IDLE});
        finishCycle();

        // Flush while waiting; the late response is drained.
        applyStimulus(32'h2200, 32'h0000_4000, 1'b1, 1'b0, 1'b0, WORD, 2'd0,
                      1'b1, 1'b0, 5'd16, 1'b0, 32'hCAFE_F00D);
        waitSample();
        finishCycle();
        idleInput();
        flush = 1'b1;
        waitSample();
        checkOutput("flushw_pass_valid", {31'b0, pass_out.valid}, 32'd0);
        checkOutput("flushw_rdy_in", {31'b0, rdy_in}, 32'd1);
        finishCycle();
        flush = 1'b0;
        waitSample();
        checkOutput("drain_state", {30'b0, dut.state}, {30'b0, DRAIN});
        checkOutput("drain_rdy_in", {31'b0, rdy_in}, 32'd0);
        checkOutput("drain_pass_valid", {31'b0, pass_out.valid}, 32'd0);
        checkOutput("drain_fwd_valid", {31'b0, fwd_req.valid}, 32'd0);
        finishCycle();
        dcache_data_valid = 1'b1;
        dcache_rdata      = 32'hCAFE_F00D;
        waitSample();
        checkOutput("drain_pulse_rdy_in", {31'b0, rdy_in}, 32'd0);
        checkOutput("drain_pulse_pass_valid", {31'b0, pass_out.valid}, 32'd0);
        finishCycle();
        dcache_data_valid = 1'b0;
        waitSample();
        checkOutput("drain_exit_state", {30'b0, dut.state}, {30'b0, IDLE});
        checkOutput("drain_exit_rdy_in", {31'b0, rdy_in}, 32'd1);
        finishCycle();

        // Flush and response in the same cycle.
        applyStimulus(32'h2300, 32'h0000_4000, 1'b1, 1'b0, 1'b0, WORD, 2'd0,
                      1'b1, 1'b0, 5'd17, 1'b0, 32'h1111_1111);
        waitSample();
        finishCycle();
        idleInput();
        flush             = 1'b1;
        dcache_data_valid = 1'b1;
        dcache_rdata      = 32'h1111_1111;
        waitSample();
        checkOutput("flushdv_pass_valid", {31'b0, pass_out.valid}, 32'd0);
        checkOutput("flushdv_fwd_valid", {31'b0, fwd_req.valid}, 32'd0);
        finishCycle();
        flush             = 1'b0;
        dcache_data_valid = 1'b0;
        waitSample();
        checkOutput("flushdv_state", {30'b0, dut.state}, {30'b0, IDLE});
        checkOutput("flushdv_rdy_in", {31'b0, rdy_in}, 32'd1);
        checkOutput("flushdv_after_valid", {31'b0, pass_out.valid}, 32'd0);
        finishCycle();

        // ALU result followed back-to-back by a link-address write.
        applyStimulus(32'h3000, 32'h0000_1234, 1'b0, 1'b0, 1'b0, WORD, 2'd0,
                      1'b1, 1'b0, 5'd5, 1'b0, 32'h0000_1234);
        waitSample();
        finishCycle();
        applyStimulus(32'h3004, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0, WORD, 2'd0,
                      1'b1, 1'b1, 5'd1, 1'b0, 32'h0000_3008);
        waitSample();
        checkOutput("b2b_alu_valid", {31'b0, pass_out.valid}, 32'd1);
        checkOutput("b2b_alu_fwd_dv", {31'b0, fwd_req.data_valid}, 32'd1);
        checkOutput("b2b_alu_fwd_data", fwd_req.data, 32'h0000_1234);
        finishCycle();
        idleInput();
        waitSample();
        checkOutput("b2b_jirl_valid", {31'b0, pass_out.valid}, 32'd1);
        checkOutput("b2b_jirl_fwd_dv", {31'b0, fwd_req.data_valid}, 32'd1);
        checkOutput("b2b_jirl_fwd_data", fwd_req.data, 32'h0000_3008);
        finishCycle();

        // Non-load stalled by writeback keeps its result and blocks input.
        applyStimulus(32'h3100, 32'h0000_0055, 1'b0, 1'b0, 1'b0, WORD, 2'd0,
                      1'b1, 1'b0, 5'd3, 1'b0, 32'h0000_0055);
        waitSample();
        finishCycle();
        idleInput();
        next_rdy_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            waitSample();
            checkOutput($sformatf("stall_rdy_in_%0d", k), {31'b0, rdy_in}, 32'd0);
            checkOutput($sformatf("stall_pass_valid_%0d", k), {31'b0, pass_out.valid}, 32'd0);
            checkOutput($sformatf("stall_rd_data_%0d", k), pass_out.rd_data, 32'h0000_0055);
            finishCycle();
        end
        next_rdy_in = 1'b1;
        waitSample();
        checkOutput("stall_release_valid", {31'b0, pass_out.valid}, 32'd1);
        finishCycle();

        // Nothing left pending.
        waitSample();
        checkOutput("sb_empty", sb_q.size(), 32'd0);
        checkOutput("reads_drained", reads_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
